// File: rtl/rca_pkg.sv
// Shared constants and result type for the ripple-carry adder.
package rca_pkg;

  localparam int RCA_DEFAULT_WIDTH = 4;

  // {cout, sum} at the default operand width.
  typedef logic [RCA_DEFAULT_WIDTH:0] rca_result_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell; one instance per bit of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_carry_adder.sv
// Ripple-carry adder with a combinational result and a one-cycle registered copy.
// Define RCA_OVF_EN to add two's-complement overflow outputs ovf/ovf_q.
module ripple_carry_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             out_valid
`ifdef RCA_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  // carry[i] enters bit i; carry[WIDTH] is the final carry out.
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .s   (sum[i]),
      .cout(carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q  <= sum;
        cout_q <= cout;
      end
    end
  end

`ifdef RCA_OVF_EN
  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign ovf = carry[WIDTH-1] ^ carry[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= ovf;
    end
  end
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder: directed vectors, hold/reset, exhaustive sweep.
module tb_ripple_carry_adder;
  import rca_pkg::*;

  localparam int W = RCA_DEFAULT_WIDTH;

  typedef struct {
    rca_result_t res;
    logic        ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         cin;
  logic         in_valid;
  logic [W-1:0] sum, sum_q;
  logic         cout, cout_q, out_valid;
`ifdef RCA_OVF_EN
  logic         ovf, ovf_q;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic exp_v;

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .in_valid (in_valid),
    .sum      (sum),
    .cout     (cout),
    .sum_q    (sum_q),
    .cout_q   (cout_q),
    .out_valid(out_valid)
`ifdef RCA_OVF_EN
    ,
    .ovf      (ovf),
    .ovf_q    (ovf_q)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    e.res = rca_result_t'(x) + rca_result_t'(y) + rca_result_t'(c);
    e.ovf = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
    return e;
  endfunction

  // Apply one vector on the falling edge, check the combinational path, queue the capture.
  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       input logic v);
    exp_t e;
    @(negedge clk);
    a = x; b = y; cin = c; in_valid = v;
    e = model(x, y, c);
    #1;
    check("sum", 64'(sum), 64'(e.res[W-1:0]));
    check("cout", 64'(cout), 64'(e.res[W]));
`ifdef RCA_OVF_EN
    check("ovf", 64'(ovf), 64'(e.ovf));
`endif
    if (v) sb.push_back(e);
  endtask

  // Monitor: out_valid follows the qualified in_valid; each result pops the scoreboard.
  always begin
    exp_t e;
    @(posedge clk);
    exp_v = in_valid && rst_n;
    #2;
    check("out_valid", 64'(out_valid), 64'(exp_v));
    if (out_valid) begin
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sum_q", 64'(sum_q), 64'(e.res[W-1:0]));
        check("cout_q", 64'(cout_q), 64'(e.res[W]));
`ifdef RCA_OVF_EN
        check("ovf_q", 64'(ovf_q), 64'(e.ovf));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_sum_q", 64'(sum_q), 64'd0);
    check("rst_cout_q", 64'(cout_q), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    #11 rst_n = 1'b1;

    // Directed vectors, back to back.
    drive(4'b0000, 4'b0000, 1'b0, 1'b1);
    drive(4'b0101, 4'b0110, 1'b0, 1'b1);
    drive(4'b1001, 4'b0111, 1'b1, 1'b1);
    drive(4'b1111, 4'b0001, 1'b1, 1'b1);
    drive(4'b1111, 4'b1111, 1'b0, 1'b1);
    drive(4'b1111, 4'b1111, 1'b1, 1'b1);

    // Load 2+3 then hold for three idle cycles.
    drive(4'b0010, 4'b0011, 1'b0, 1'b1);
    repeat (3) begin
      drive(4'b0111, 4'b0001, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      check("hold_sum_q", 64'(sum_q), 64'h5);
      check("hold_out_valid", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset between edges clears registers; combinational path stays live.
    #1 rst_n = 1'b0;
    #1;
    check("async_sum_q", 64'(sum_q), 64'd0);
    check("async_cout_q", 64'(cout_q), 64'd0);
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("rst_comb_sum", 64'(sum), 64'h8);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted with a result pending discards it.
    drive(4'b1001, 4'b1001, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    check("discard_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #3;
    check("in_rst_sum_q", 64'(sum_q), 64'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("post_rst_sum_q", 64'(sum_q), 64'd0);
    drive(4'b0100, 4'b0100, 1'b1, 1'b1);

    // Exhaustive sweep with every vector captured back to back.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      drive(v[8:5], v[4:1], v[0], 1'b1);
    end

    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder.md
RIPPLE_CARRY_ADDER -- requirements
Module: ripple_carry_adder

Interface
REQ-001 Parameter: WIDTH, default 4, operand/sum bit width (legal range 1..64).
REQ-002 Port: clk  input  1  single clock; all registered outputs update on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: a  input  WIDTH  unsigned operand A.
REQ-005 Port: b  input  WIDTH  unsigned operand B.
REQ-006 Port: cin  input  1  carry into bit 0.
REQ-007 Port: in_valid  input  1  qualifies a/b/cin for capture into the output registers.
REQ-008 Port: sum  output  WIDTH  combinational sum bits.
REQ-009 Port: cout  output  1  combinational carry out of bit WIDTH-1.
REQ-010 Port: sum_q  output  WIDTH  registered sum.
REQ-011 Port: cout_q  output  1  registered carry out.
REQ-012 Port: out_valid  output  1  high for the cycle after a cycle with in_valid=1.

Function
REQ-013 {cout,sum} SHALL equal a + b + cin, computed at WIDTH+1 bits, no truncation of the carry.
REQ-014 Carry SHALL ripple bit 0 to bit WIDTH-1 through WIDTH chained full-adder cells; no lookahead logic.
REQ-015 Per cell: s = a ^ b ^ c; c_next = (a & b) | (c & (a ^ b)).
REQ-016 sum/cout SHALL be purely combinational, with zero latency and independent of clk and rst_n.
REQ-017 On a rising clk edge with in_valid=1, sum_q/cout_q SHALL load sum/cout; latency is 1 cycle.
REQ-018 On a rising clk edge with in_valid=0, sum_q/cout_q SHALL hold; out_valid SHALL go 0.
REQ-019 out_valid SHALL equal in_valid delayed by one cycle; back-to-back in_valid yields back-to-back results.
REQ-020 Wrap-around: an all-ones result plus carry SHALL wrap sum to the low WIDTH bits and set cout=1.

Reset
REQ-021 rst_n=0 SHALL immediately clear sum_q, cout_q and out_valid (and ovf_q if present) to 0, regardless of clk.
REQ-022 Reset assertion mid-stream SHALL discard any pending result; the first capture after release occurs on the first rising edge with rst_n=1 and in_valid=1.
REQ-023 The combinational outputs sum/cout SHALL be unaffected by reset.

Configuration
REQ-024 Macro RCA_OVF_EN defined: add output ports ovf (combinational, 1 bit) and ovf_q (registered like sum_q), where ovf = carry into MSB XOR cout (two's-complement overflow).
REQ-025 RCA_OVF_EN undefined: ovf and ovf_q ports and their logic SHALL not exist; all other behaviour is identical.

Structure
REQ-026 Package rca_pkg SHALL hold the RCA_DEFAULT_WIDTH constant (4) and the typedef for the WIDTH+1 result.
REQ-027 Sub-module full_adder (inputs a, b, cin; outputs s, cout) SHALL be instantiated WIDTH times via generate.
REQ-028 The output register stage SHALL live in ripple_carry_adder itself, not in full_adder.

Verification
REQ-029 a=0000, b=0000, cin=0 -> sum=0000, cout=0; after one edge with in_valid=1, sum_q=0000 and out_valid=1.
REQ-030 a=0101, b=0110, cin=0 -> sum=1011, cout=0 (ovf=1 with RCA_OVF_EN).
REQ-031 a=1001, b=0111, cin=1 -> sum=0001, cout=1; a=1111, b=0001, cin=1 -> sum=0001, cout=1.
REQ-032 a=1111, b=1111, cin=0 -> sum=1110, cout=1; registered one cycle later.
REQ-033 Load 0010+0011 (sum_q=0101), drop in_valid for 3 cycles -> sum_q holds 0101 and out_valid=0; assert rst_n=0 between edges -> sum_q, cout_q and out_valid read 0 immediately.
REQ-034 Exhaustive sweep of all 512 (a,b,cin) combinations at WIDTH=4 -> combinational and registered outputs match a+b+cin.
